segment_param_sequencer: RTL and testbench

Double-buffered parameter sequencer for the multi-channel wave generator. It collects per-channel amplitude, offset and phase-word values into a shadow bank through a streaming write port. On commit it transfers them to the active bank driving the generator array, then counts down a per-segment duration. It generalises the fixed 64-channel load/run/expire flow with these additions:
- parametrised channel count and width
- seamless back-to-back segments
- loop mode
- stop control
- overflow and underrun reporting

---
 rtl/segment_param_sequencer.sv | 148 ++++++++++++++
 tb/tb_segment_param_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_param_sequencer.sv
// Double-buffered parameter sequencer: streams channel parameters into a shadow bank,
// commits them to the active bank and times each segment with seamless chaining and looping.
module segment_param_sequencer #(
    parameter int unsigned NCH = 64,
    parameter int unsigned DW  = 16,
    parameter int unsigned TW  = 16,
    parameter int unsigned AW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [DW-1:0]     wr_data,
    input  logic              wr_ptr_clr,
    input  logic [TW-1:0]     load_time,
    input  logic              load_done,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    output logic [NCH*DW-1:0] active_amps,
    output logic [NCH*DW-1:0] active_offsets,
    output logic [NCH*DW-1:0] active_phasewords,
    output logic              gen_reset,
    output logic              gen_active,
    output logic [TW-1:0]     cur_time,
    output logic              shadow_pending,
    output logic              finished,
    output logic              underrun,
    output logic              wr_overflow
);

    typedef enum logic [1:0] {StIdle, StCommit, StRun} state_e;

    localparam logic [AW:0] PtrFull = (AW+1)'(NCH);

    state_e              state_q, state_d;
    logic [NCH*DW-1:0]   shadow_amps_q, shadow_offsets_q, shadow_phasewords_q;
    logic [TW-1:0]       shadow_time_q, seg_time_q;
    logic [AW:0]         wr_ptr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start && shadow_pending) state_d = StCommit;
            StCommit: state_d = StRun;
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cur_time == '0) begin
                    if (shadow_pending)  state_d = StCommit;
                    else if (!loop_mode) state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            shadow_amps_q       <= '0;
            shadow_offsets_q    <= '0;
            shadow_phasewords_q <= '0;
            shadow_time_q       <= '0;
            seg_time_q          <= '0;
            wr_ptr_q            <= '0;
            active_amps         <= '0;
            active_offsets      <= '0;
            active_phasewords   <= '0;
            gen_reset           <= 1'b0;
            gen_active          <= 1'b0;
            cur_time            <= '0;
            shadow_pending      <= 1'b0;
            finished            <= 1'b0;
            underrun            <= 1'b0;
            wr_overflow         <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_active <= (state_d != StIdle);
            gen_reset  <= 1'b0;
            finished   <= 1'b0;
            underrun   <= 1'b0;

            // Only a phase-word write advances the pointer, closing out that channel.
            if (wr_ptr_clr) begin
                wr_ptr_q    <= '0;
                wr_overflow <= 1'b0;
            end else if (wr_en && wr_sel != 2'd3) begin
                if (wr_ptr_q >= PtrFull) begin
                    wr_overflow <= 1'b1;
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        if (wr_ptr_q == (AW+1)'(i)) begin
                            case (wr_sel)
                                2'd0:    shadow_amps_q[i*DW +: DW]       <= wr_data;
                                2'd1:    shadow_offsets_q[i*DW +: DW]    <= wr_data;
                                default: shadow_phasewords_q[i*DW +: DW] <= wr_data;
                            endcase
                        end
                    end
                    if (wr_sel == 2'd2) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                end
            end

            if (load_done) begin
                shadow_pending <= 1'b1;
                shadow_time_q  <= load_time;
            end

            case (state_q)
                StIdle: begin
                    if (start && !shadow_pending) underrun <= 1'b1;
                end
                StCommit: begin
                    active_amps       <= shadow_amps_q;
                    active_offsets    <= shadow_offsets_q;
                    active_phasewords <= shadow_phasewords_q;
                    seg_time_q        <= shadow_time_q;
                    cur_time          <= shadow_time_q;
                    gen_reset         <= 1'b1;
                    if (!load_done) shadow_pending <= 1'b0;
                end
                StRun: begin
                    if (stop) begin
                        active_amps       <= '0;
                        active_offsets    <= '0;
                        active_phasewords <= '0;
                    end else if (cur_time != '0) begin
                        cur_time <= cur_time - TW'(1);
                    end else if (shadow_pending) begin
                        // Next segment commits next cycle; outputs hold to avoid a gap.
                    end else if (loop_mode) begin
                        cur_time  <= seg_time_q;
                        gen_reset <= 1'b1;
                    end else begin
                        active_amps       <= '0;
                        active_offsets    <= '0;
                        active_phasewords <= '0;
                        cur_time          <= '0;
                        finished          <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_param_sequencer.sv
// Randomized self-checking bench for segment_param_sequencer (NCH=4, DW=16).
module tb_segment_param_sequencer;

    logic        clk = 1'b0;
    logic        reset, wr_en, wr_ptr_clr, load_done, start, stop, loop_mode;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data, load_time;
    logic [63:0] active_amps, active_offsets, active_phasewords;
    logic        gen_reset, gen_active, shadow_pending, finished, underrun, wr_overflow;
    logic [15:0] cur_time;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the shadow side
    logic [15:0] m_amp [4];
    logic [15:0] m_off [4];
    logic [15:0] m_ph  [4];
    int          m_ptr;
    bit          m_ovf;

    segment_param_sequencer #(.NCH(4), .DW(16), .TW(16), .AW(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ptr_clr(wr_ptr_clr), .load_time(load_time), .load_done(load_done),
        .start(start), .stop(stop), .loop_mode(loop_mode),
        .active_amps(active_amps), .active_offsets(active_offsets),
        .active_phasewords(active_phasewords), .gen_reset(gen_reset),
        .gen_active(gen_active), .cur_time(cur_time), .shadow_pending(shadow_pending),
        .finished(finished), .underrun(underrun), .wr_overflow(wr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_amp[i] = '0; m_off[i] = '0; m_ph[i] = '0;
        end
        m_ptr = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_write(input logic [1:0] sel, input logic [15:0] d);
        if (sel == 2'd3) return;
        if (m_ptr >= 4) begin
            m_ovf = 1'b1;
            return;
        end
        case (sel)
            2'd0:    m_amp[m_ptr] = d;
            2'd1:    m_off[m_ptr] = d;
            default: m_ph[m_ptr]  = d;
        endcase
        if (sel == 2'd2) m_ptr++;
    endfunction

    function automatic logic [63:0] pack_bank(input int sel);
        logic [63:0] v;
        for (int i = 0; i < 4; i++)
            v[i*16 +: 16] = (sel == 0) ? m_amp[i] : (sel == 1) ? m_off[i] : m_ph[i];
        return v;
    endfunction

    task automatic do_write(input logic [1:0] sel, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        model_write(sel, d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_ptr();
        wr_ptr_clr = 1'b1;
        m_ptr = 0; m_ovf = 1'b0;
        tick();
        wr_ptr_clr = 1'b0;
    endtask

    task automatic load_segment(input int t, input bit fixed);
        clear_ptr();
        for (int ch = 0; ch < 4; ch++) begin
            do_write(2'd0, fixed ? 16'h1000 + 16'(ch) : 16'($urandom));
            do_write(2'd1, fixed ? 16'h0010 : 16'($urandom));
            do_write(2'd2, fixed ? 16'h0100 : 16'($urandom));
        end
        load_done = 1'b1; load_time = 16'(t);
        tick();
        load_done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if ({active_amps, active_offsets, active_phasewords} !== '0)
            $display("FAIL reset_banks: got %h want 0", {active_amps, active_offsets});
        else n_pass++;
        n_checks++;
        if ({gen_reset, gen_active, cur_time, shadow_pending, finished, underrun, wr_overflow}
            !== '0)
            $display("FAIL reset_ctrl: got %b want 0",
                     {gen_reset, gen_active, cur_time, shadow_pending, finished, underrun,
                      wr_overflow});
        else n_pass++;
    endtask

    // Iteration 0 is the fixed basic pattern (T=3); the rest use random data and duration.
    task automatic test_single_runs();
        logic [63:0] ea, eo, ep;
        for (int it = 0; it < 6; it++) begin
            int t;
            t = (it == 0) ? 3 : int'($urandom_range(0, 6));
            load_segment(t, it == 0);
            n_checks++;
            if (shadow_pending !== 1'b1) $display("FAIL run_pending: got %b want 1", shadow_pending);
            else n_pass++;
            ea = pack_bank(0); eo = pack_bank(1); ep = pack_bank(2);
            pulse_start();
            n_checks++;
            if (gen_active !== 1'b1 || gen_reset !== 1'b0)
                $display("FAIL run_commit: got act=%b rst=%b want act=1 rst=0", gen_active, gen_reset);
            else n_pass++;
            tick();
            n_checks++;
            if ({active_amps, active_offsets, active_phasewords} !== {ea, eo, ep})
                $display("FAIL run_banks: got %h %h %h want %h %h %h", active_amps,
                         active_offsets, active_phasewords, ea, eo, ep);
            else n_pass++;
            n_checks++;
            if (cur_time !== 16'(t) || gen_reset !== 1'b1 || shadow_pending !== 1'b0)
                $display("FAIL run_first: got t=%0d rst=%b pend=%b want t=%0d rst=1 pend=0",
                         cur_time, gen_reset, shadow_pending, t);
            else n_pass++;
            for (int k = 1; k <= t; k++) begin
                tick();
                n_checks++;
                if (cur_time !== 16'(t - k) || gen_reset !== 1'b0 || gen_active !== 1'b1 ||
                    finished !== 1'b0)
                    $display("FAIL run_count: got t=%0d rst=%b act=%b fin=%b want t=%0d 0 1 0",
                             cur_time, gen_reset, gen_active, finished, t - k);
                else n_pass++;
            end
            tick();
            n_checks++;
            if (finished !== 1'b1 || gen_active !== 1'b0 || active_amps !== '0 ||
                active_phasewords !== '0 || cur_time !== '0)
                $display("FAIL run_end: got fin=%b act=%b amps=%h t=%0d want 1 0 0 0",
                         finished, gen_active, active_amps, cur_time);
            else n_pass++;
            tick();
            n_checks++;
            if (finished !== 1'b0) $display("FAIL run_fin_pulse: got %b want 0", finished);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ea, eo, ep, ba, bo, bp;
        load_segment(2, 1'b0);
        clear_ptr();
        ea = pack_bank(0); eo = pack_bank(1); ep = pack_bank(2);
        pulse_start();
        do_write(2'd0, 16'h2222);  // lands in the commit cycle
        n_checks++;
        if ({active_amps, active_offsets, active_phasewords} !== {ea, eo, ep} ||
            cur_time !== 16'd2)
            $display("FAIL b2b_a_banks: got amps=%h t=%0d want amps=%h t=2",
                     active_amps, cur_time, ea);
        else n_pass++;
        load_done = 1'b1; load_time = 16'd1;
        tick();
        load_done = 1'b0;
        n_checks++;
        if (cur_time !== 16'd1 || shadow_pending !== 1'b1)
            $display("FAIL b2b_b_pending: got t=%0d pend=%b want 1 1", cur_time, shadow_pending);
        else n_pass++;
        tick();
        n_checks++;
        if (cur_time !== 16'd0 || finished !== 1'b0 || gen_active !== 1'b1)
            $display("FAIL b2b_a_last: got t=%0d fin=%b act=%b want 0 0 1",
                     cur_time, finished, gen_active);
        else n_pass++;
        ba = pack_bank(0); bo = pack_bank(1); bp = pack_bank(2);
        tick();
        n_checks++;
        if (gen_active !== 1'b1 || finished !== 1'b0)
            $display("FAIL b2b_gap: got act=%b fin=%b want 1 0", gen_active, finished);
        else n_pass++;
        tick();
        n_checks++;
        if ({active_amps, active_offsets, active_phasewords} !== {ba, bo, bp} ||
            active_amps[15:0] !== 16'h2222 || cur_time !== 16'd1 || gen_reset !== 1'b1)
            $display("FAIL b2b_b_first: got amps=%h t=%0d rst=%b want amps=%h t=1 rst=1",
                     active_amps, cur_time, gen_reset, ba);
        else n_pass++;
        tick();
        n_checks++;
        if (cur_time !== 16'd0 || finished !== 1'b0)
            $display("FAIL b2b_b_last: got t=%0d fin=%b want 0 0", cur_time, finished);
        else n_pass++;
        tick();
        n_checks++;
        if (finished !== 1'b1 || gen_active !== 1'b0)
            $display("FAIL b2b_end: got fin=%b act=%b want 1 0", finished, gen_active);
        else n_pass++;
    endtask

    task automatic test_loop();
        logic [63:0] ea;
        load_segment(1, 1'b0);
        ea = pack_bank(0);
        loop_mode = 1'b1;
        pulse_start();
        tick();
        for (int r = 0; r < 3; r++) begin
            n_checks++;
            if (cur_time !== 16'd1 || gen_reset !== 1'b1 || gen_active !== 1'b1 ||
                active_amps !== ea)
                $display("FAIL loop_reload%0d: got t=%0d rst=%b act=%b want 1 1 1",
                         r, cur_time, gen_reset, gen_active);
            else n_pass++;
            if (r == 2) loop_mode = 1'b0;
            tick();
            n_checks++;
            if (cur_time !== 16'd0 || gen_reset !== 1'b0 || finished !== 1'b0)
                $display("FAIL loop_zero%0d: got t=%0d rst=%b fin=%b want 0 0 0",
                         r, cur_time, gen_reset, finished);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (finished !== 1'b1 || gen_active !== 1'b0 || active_amps !== '0)
            $display("FAIL loop_end: got fin=%b act=%b want 1 0", finished, gen_active);
        else n_pass++;
    endtask

    task automatic test_overflow();
        clear_ptr();
        for (int i = 0; i < 4; i++) do_write(2'd2, 16'($urandom));
        n_checks++;
        if (wr_overflow !== 1'b0) $display("FAIL ovf_four: got %b want 0", wr_overflow);
        else n_pass++;
        do_write(2'd2, 16'($urandom));
        n_checks++;
        if (wr_overflow !== 1'($unsigned(m_ovf)) || wr_overflow !== 1'b1)
            $display("FAIL ovf_fifth: got %b want 1", wr_overflow);
        else n_pass++;
        load_done = 1'b1; load_time = 16'd0;
        tick();
        load_done = 1'b0;
        pulse_start();
        tick();
        n_checks++;
        if (active_phasewords !== pack_bank(2))
            $display("FAIL ovf_dropped: got %h want %h", active_phasewords, pack_bank(2));
        else n_pass++;
        tick();
        clear_ptr();
        n_checks++;
        if (wr_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", wr_overflow);
        else n_pass++;
        do_write(2'd0, 16'($urandom));
        do_write(2'd2, 16'($urandom));
        do_write(2'd0, 16'($urandom));
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        pulse_start();
        tick();
        n_checks++;
        if (active_amps !== pack_bank(0) || active_phasewords !== pack_bank(2))
            $display("FAIL ovf_ptr_zero: got %h %h want %h %h", active_amps, active_phasewords,
                     pack_bank(0), pack_bank(2));
        else n_pass++;
        tick();
    endtask

    task automatic test_stop_reset();
        load_segment(8, 1'b0);
        pulse_start();
        tick(); tick(); tick(); tick();
        n_checks++;
        if (cur_time !== 16'd5) $display("FAIL stop_at5: got %0d want 5", cur_time);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (gen_active !== 1'b0 || active_amps !== '0 || active_offsets !== '0 || finished !== 1'b0)
            $display("FAIL stop_idle: got act=%b amps=%h fin=%b want 0 0 0",
                     gen_active, active_amps, finished);
        else n_pass++;
        tick();
        n_checks++;
        if (finished !== 1'b0 || gen_active !== 1'b0)
            $display("FAIL stop_nofin: got fin=%b act=%b want 0 0", finished, gen_active);
        else n_pass++;
        load_segment(8, 1'b0);
        pulse_start();
        tick(); tick();
        do_write(2'd2, 16'h5a5a);
        n_checks++;
        if (wr_overflow !== 1'b1 || gen_active !== 1'b1)
            $display("FAIL rst_pre: got ovf=%b act=%b want 1 1", wr_overflow, gen_active);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if ({active_amps, active_offsets, active_phasewords, gen_reset, gen_active, cur_time,
             shadow_pending, finished, underrun, wr_overflow} !== '0)
            $display("FAIL rst_mid: got amps=%h act=%b t=%0d pend=%b ovf=%b want all 0",
                     active_amps, gen_active, cur_time, shadow_pending, wr_overflow);
        else n_pass++;
    endtask

    task automatic test_underrun_simul();
        bit ok;
        pulse_start();
        n_checks++;
        if (underrun !== 1'b1 || gen_active !== 1'b0)
            $display("FAIL underrun_pulse: got und=%b act=%b want 1 0", underrun, gen_active);
        else n_pass++;
        tick();
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL underrun_single: got %b want 0", underrun);
        else n_pass++;
        load_segment(2, 1'b0);
        pulse_start();
        load_done = 1'b1; load_time = 16'd1; start = 1'b1;
        tick();
        load_done = 1'b0; start = 1'b0;
        n_checks++;
        if (shadow_pending !== 1'b1 || underrun !== 1'b0 || cur_time !== 16'd2)
            $display("FAIL simul_pending: got pend=%b und=%b t=%0d want 1 0 2",
                     shadow_pending, underrun, cur_time);
        else n_pass++;
        ok = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (gen_active !== 1'b1 || finished !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL simul_chain: got early gap or finish want none");
        else n_pass++;
        tick();
        n_checks++;
        if (finished !== 1'b1 || gen_active !== 1'b0)
            $display("FAIL simul_end: got fin=%b act=%b want 1 0", finished, gen_active);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_data = '0; wr_ptr_clr = 1'b0;
        load_time = '0; load_done = 1'b0; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_single_runs();
        test_back_to_back();
        test_loop();
        test_overflow();
        test_stop_reset();
        test_underrun_simul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
